// File: rtl/sse_frame_ctrl.sv
// Frame sequencer for the ScaleSpaceExtrema core: select handoff, core reset pulse, one-frame
// input gating, output counting, and clean aborts on stream close or stall.
module sse_frame_ctrl #(
  parameter int unsigned IMG_PIXELS   = 307200,
  parameter int unsigned OUT_PIXELS   = 307200,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned STALL_LIMIT  = 65535
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic        streams_open,
  input  logic        sel_fifo_empty,
  output logic        sel_fifo_rden,
  input  logic        in_fifo_empty,
  output logic        in_fifo_rden,
  input  logic        out_fifo_full,
  output logic        out_fifo_wren,
  output logic        core_reset,
  output logic        core_select_valid,
  input  logic        core_select_ready,
  output logic        core_img_in_valid,
  input  logic        core_img_in_ready,
  input  logic        core_img_out_valid,
  output logic        core_img_out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        error,
  output logic [15:0] frame_count
);

  localparam int unsigned RstW   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  localparam logic [CNT_W-1:0]  ImgPix   = CNT_W'(IMG_PIXELS);
  localparam logic [CNT_W-1:0]  OutPix   = CNT_W'(OUT_PIXELS);
  localparam logic [RstW-1:0]   RstLast  = RstW'(RESET_CYCLES - 1);
  localparam logic [StallW-1:0] StallLim = StallW'(STALL_LIMIT);

  typedef enum logic [2:0] {StIdle, StCoreRst, StSelect, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [RstW-1:0]     rst_cnt_q;
  logic                in_select, in_stream, stall_abort;

  // Handshakes are purely combinational so a transfer lands in the cycle both sides agree.
  always_comb begin
    in_select          = (state_q == StSelect);
    in_stream          = (state_q == StStream);
    core_select_valid  = in_select & ~sel_fifo_empty;
    sel_fifo_rden      = core_select_valid & core_select_ready;
    core_img_in_valid  = in_stream & ~in_fifo_empty & (in_cnt_q < ImgPix);
    in_fifo_rden       = core_img_in_valid & core_img_in_ready;
    core_img_out_ready = in_stream & ~out_fifo_full;
    out_fifo_wren      = in_stream & core_img_out_valid & ~out_fifo_full;
  end

  always_comb begin
    in_cnt_d    = in_cnt_q + CNT_W'(in_fifo_rden);
    out_cnt_d   = out_cnt_q + CNT_W'(out_fifo_wren);
    stall_cnt_d = (in_fifo_rden | out_fifo_wren) ? '0 : stall_cnt_q + 1'b1;
    stall_abort = in_stream & streams_open & (stall_cnt_d == StallLim);
    state_d     = state_q;
    unique case (state_q)
      StIdle:    if (!sel_fifo_empty && streams_open) state_d = StCoreRst;
      StCoreRst: if (rst_cnt_q == RstLast) state_d = StSelect;
      StSelect:  if (sel_fifo_rden) state_d = StStream;
      StStream: begin
        if (stall_abort) state_d = StIdle;
        else if (out_cnt_d == OutPix) state_d = StDone;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // A closed stream overrides everything, including a simultaneous completion.
    if (state_q != StIdle && !streams_open) state_d = StIdle;
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
      rst_cnt_q   <= '0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_stream ? in_cnt_d : '0;
      out_cnt_q   <= in_stream ? out_cnt_d : '0;
      stall_cnt_q <= in_stream ? stall_cnt_d : '0;
      rst_cnt_q   <= (state_q == StCoreRst) ? rst_cnt_q + 1'b1 : '0;
      core_reset  <= (state_d == StIdle) || (state_d == StCoreRst);
      busy        <= (state_d != StIdle);
      frame_done  <= (state_d == StDone);
      if (state_d == StDone) frame_count <= frame_count + 16'd1;
      if (stall_abort) error <= 1'b1;
      else if (state_d == StCoreRst && state_q != StCoreRst) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sse_frame_ctrl.sv
// Directed bench for sse_frame_ctrl: FIFO and core behaviour modelled in the bench, expected
// counts and cycle offsets worked out by hand for 16-pixel frames.
module tb_sse_frame_ctrl;

  localparam int unsigned Pix = 16;

  logic        bus_clk = 1'b0;
  logic        reset_n;
  logic        streams_open;
  logic        sel_fifo_empty, sel_fifo_rden;
  logic        in_fifo_empty, in_fifo_rden;
  logic        out_fifo_full, out_fifo_wren;
  logic        core_reset;
  logic        core_select_valid, core_select_ready;
  logic        core_img_in_valid, core_img_in_ready;
  logic        core_img_out_valid, core_img_out_ready;
  logic        busy, frame_done, error;
  logic [15:0] frame_count;

  // Bench-side FIFO and core models
  int unsigned sel_pushed = 0, sel_popped = 0, in_pushed = 0, in_popped = 0, out_written = 0;
  int unsigned core_in = 0, core_out = 0, out_limit = 1000;
  logic        in_en = 1'b1, out_en = 1'b1, bp_en = 1'b0, bp_phase = 1'b0;
  logic        hs_sel_s = 1'b0, hs_in_s = 1'b0, hs_out_s = 1'b0, crst_s = 1'b1;
  int unsigned cyc = 0, last_hs = 0, last_wren = 0, done_cyc = 0, done_pulses = 0;
  int unsigned rst_cycles = 0, rdy_full = 0, wren_full = 0;

  int unsigned n_cmp = 0, n_err = 0;

  assign sel_fifo_empty     = (sel_pushed == sel_popped);
  assign in_fifo_empty      = (in_pushed == in_popped);
  assign out_fifo_full      = bp_en & bp_phase;
  assign core_select_ready  = 1'b1;
  assign core_img_in_ready  = in_en;
  assign core_img_out_valid = out_en && (core_in > core_out) && (core_out < out_limit);

  sse_frame_ctrl #(
    .IMG_PIXELS  (Pix),
    .OUT_PIXELS  (Pix),
    .CNT_W       (20),
    .RESET_CYCLES(4),
    .STALL_LIMIT (32)
  ) u_dut (
    .bus_clk           (bus_clk),
    .reset_n           (reset_n),
    .streams_open      (streams_open),
    .sel_fifo_empty    (sel_fifo_empty),
    .sel_fifo_rden     (sel_fifo_rden),
    .in_fifo_empty     (in_fifo_empty),
    .in_fifo_rden      (in_fifo_rden),
    .out_fifo_full     (out_fifo_full),
    .out_fifo_wren     (out_fifo_wren),
    .core_reset        (core_reset),
    .core_select_valid (core_select_valid),
    .core_select_ready (core_select_ready),
    .core_img_in_valid (core_img_in_valid),
    .core_img_in_ready (core_img_in_ready),
    .core_img_out_valid(core_img_out_valid),
    .core_img_out_ready(core_img_out_ready),
    .busy              (busy),
    .frame_done        (frame_done),
    .error             (error),
    .frame_count       (frame_count)
  );

  always #5 bus_clk = ~bus_clk;

  // Strobes are sampled mid-cycle and applied to the models at the following rising edge.
  always @(negedge bus_clk) begin
    hs_sel_s <= sel_fifo_rden;
    hs_in_s  <= in_fifo_rden;
    hs_out_s <= out_fifo_wren;
    crst_s   <= core_reset;
    cyc      <= cyc + 1;
    if (in_fifo_rden || out_fifo_wren) last_hs <= cyc;
    if (out_fifo_wren) last_wren <= cyc;
    if (frame_done) begin
      done_pulses <= done_pulses + 1;
      done_cyc    <= cyc;
    end
    if (busy && core_reset) rst_cycles <= rst_cycles + 1;
    if (out_fifo_full && core_img_out_ready) rdy_full <= rdy_full + 1;
    if (out_fifo_full && out_fifo_wren) wren_full <= wren_full + 1;
  end

  always @(posedge bus_clk) begin
    if (hs_sel_s) sel_popped <= sel_popped + 1;
    if (hs_in_s) in_popped <= in_popped + 1;
    if (hs_out_s) out_written <= out_written + 1;
    if (bp_en) bp_phase <= ~bp_phase;
    if (crst_s) begin
      core_in  <= 0;
      core_out <= 0;
    end else begin
      if (hs_in_s) core_in <= core_in + 1;
      if (hs_out_s) core_out <= core_out + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input string tag, input logic val);
    int n = 0;
    while (busy !== val && n < 3000) begin
      @(negedge bus_clk);
      n++;
    end
    check_eq(tag, 32'(busy === val), 1);
  endtask

  task automatic wait_core_in(input string tag, input int unsigned v);
    int n = 0;
    while (core_in < v && n < 3000) begin
      @(negedge bus_clk);
      n++;
    end
    check_eq(tag, 32'(core_in >= v), 1);
  endtask

  int unsigned b_in, b_out, b_done, b_rst;

  task automatic snap();
    b_in   = in_popped;
    b_out  = out_written;
    b_done = done_pulses;
    b_rst  = rst_cycles;
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    streams_open = 1'b0;
    repeat (3) @(negedge bus_clk);
    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_strobes", {sel_fifo_rden, in_fifo_rden, out_fifo_wren, core_select_valid,
                             core_img_in_valid, core_img_out_ready}, 0);
    reset_n      = 1'b1;
    streams_open = 1'b1;
    repeat (2) @(negedge bus_clk);

    // Nominal frame: 20 words queued, core always ready and echoing.
    snap();
    in_pushed  += 20;
    sel_pushed += 1;
    wait_busy("nom_start", 1);
    wait_busy("nom_end", 0);
    repeat (2) @(negedge bus_clk);
    check_eq("nom_in_reads", in_popped - b_in, 16);
    check_eq("nom_out_writes", out_written - b_out, 16);
    check_eq("nom_core_rst_len", rst_cycles - b_rst, 4);
    check_eq("nom_done_pulses", done_pulses - b_done, 1);
    check_eq("nom_done_latency", done_cyc - last_wren, 1);
    check_eq("nom_frame_count", frame_count, 1);
    check_eq("nom_in_left", in_pushed - in_popped, 4);
    check_eq("nom_sel_left", sel_pushed - sel_popped, 0);

    // Backpressure: output FIFO full on alternate cycles.
    snap();
    bp_en       = 1'b1;
    in_pushed  += 12;
    sel_pushed += 1;
    wait_busy("bp_start", 1);
    wait_busy("bp_end", 0);
    repeat (2) @(negedge bus_clk);
    bp_en = 1'b0;
    check_eq("bp_out_writes", out_written - b_out, 16);
    check_eq("bp_in_reads", in_popped - b_in, 16);
    check_eq("bp_ready_while_full", rdy_full, 0);
    check_eq("bp_wren_while_full", wren_full, 0);
    check_eq("bp_done_pulses", done_pulses - b_done, 1);
    check_eq("bp_frame_count", frame_count, 2);

    // Stall abort: core stops emitting after 10 outputs.
    snap();
    out_limit   = 10;
    in_pushed  += 16;
    sel_pushed += 1;
    wait_busy("stall_start", 1);
    n = 0;
    while (error !== 1'b1 && n < 500) begin
      @(negedge bus_clk);
      n++;
    end
    check_eq("stall_seen", 32'(error === 1'b1), 1);
    check_eq("stall_latency", cyc - last_hs, 33);
    check_eq("stall_busy", busy, 0);
    check_eq("stall_core_reset", core_reset, 1);
    check_eq("stall_out_writes", out_written - b_out, 10);
    check_eq("stall_in_reads", in_popped - b_in, 16);
    repeat (2) @(negedge bus_clk);
    check_eq("stall_no_done", done_pulses - b_done, 0);
    check_eq("stall_frame_count", frame_count, 2);
    check_eq("stall_error_sticky", error, 1);
    out_limit = 1000;

    // Close abort at in_cnt=7; also error must clear on entering the core reset.
    snap();
    in_pushed  += 16;
    sel_pushed += 1;
    wait_busy("close_start", 1);
    check_eq("close_error_cleared", error, 0);
    wait_core_in("close_reach7", 7);
    streams_open = 1'b0;
    @(negedge bus_clk);
    check_eq("close_busy", busy, 0);
    check_eq("close_core_reset", core_reset, 1);
    repeat (3) @(negedge bus_clk);
    check_eq("close_no_done", done_pulses - b_done, 0);
    check_eq("close_frame_count", frame_count, 2);
    streams_open = 1'b1;
    @(negedge bus_clk);

    // Back-to-back: two selects queued.
    snap();
    in_pushed  += 32;
    sel_pushed += 2;
    wait_busy("b2b_start1", 1);
    wait_busy("b2b_end1", 0);
    wait_busy("b2b_start2", 1);
    wait_busy("b2b_end2", 0);
    repeat (2) @(negedge bus_clk);
    check_eq("b2b_done_pulses", done_pulses - b_done, 2);
    check_eq("b2b_core_rst_len", rst_cycles - b_rst, 8);
    check_eq("b2b_out_writes", out_written - b_out, 32);
    check_eq("b2b_frame_count", frame_count, 4);
    check_eq("b2b_sel_left", sel_pushed - sel_popped, 0);

    // Asynchronous reset in the middle of streaming.
    sel_pushed += 1;
    wait_busy("mid_start", 1);
    wait_core_in("mid_reach3", 3);
    reset_n = 1'b0;
    #1;
    check_eq("mid_core_reset", core_reset, 1);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_frame_count", frame_count, 0);
    check_eq("mid_error", error, 0);
    check_eq("mid_frame_done", frame_done, 0);
    check_eq("mid_strobes", {sel_fifo_rden, in_fifo_rden, out_fifo_wren, core_select_valid,
                             core_img_in_valid, core_img_out_ready}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sse_frame_ctrl.md
# sse_frame_ctrl

Frame sequencer for the ScaleSpaceExtrema core on `bus_clk`. It sits between the select FIFO, the image-in and image-out 32-bit FIFOs and the core. For each frame it takes one select byte, pulses the core reset, hands the byte to the core, then gates the input stream to exactly one frame of pixels and counts output pixels to completion. It also aborts cleanly on stream close or stall. Data buses are wired directly FIFO↔core; this block owns only handshakes and sequencing.

## Interface
- `IMG_PIXELS`, 307200, input pixels per frame (≥1)
- `OUT_PIXELS`, 307200, output pixels per frame (≥1)
- `CNT_W`, 20, pixel counter width; must hold max(IMG_PIXELS, OUT_PIXELS)
- `RESET_CYCLES`, 4, minimum core-reset pulse length (≥1)
- `STALL_LIMIT`, 65535, idle cycles in STREAM before abort (≥1)

Ports:
- `bus_clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous active-low reset
- `streams_open`  in  1  OR of write_32/read_32/write_8 open flags
- `sel_fifo_empty`  in  1  select FIFO empty
- `sel_fifo_rden`  out  1  select FIFO read strobe
- `in_fifo_empty`  in  1  image-in FIFO empty
- `in_fifo_rden`  out  1  image-in FIFO read strobe
- `out_fifo_full`  in  1  image-out FIFO full
- `out_fifo_wren`  out  1  image-out FIFO write strobe
- `core_reset`  out  1  active-high reset to core
- `core_select_valid` out 1 / `core_select_ready` in 1
- `core_img_in_valid` out 1 / `core_img_in_ready` in 1
- `core_img_out_valid` in 1 / `core_img_out_ready` out 1
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at frame completion
- `error`  out  1  sticky; stall abort occurred
- `frame_count`  out  16  completed frames, wraps at 65535→0

## Operation
- States: IDLE, CORE_RST, SELECT, STREAM, DONE.
- IDLE: `core_reset`=1. Counters cleared. If `!sel_fifo_empty && streams_open` → CORE_RST.
- CORE_RST: `core_reset`=1 for exactly RESET_CYCLES cycles. `error` cleared on entry. → SELECT.
- SELECT: `core_reset`=0. `core_select_valid`=!sel_fifo_empty. `sel_fifo_rden`=`core_select_valid & core_select_ready`. On that handshake → STREAM.
- STREAM:
  - Input gating: `core_img_in_valid`=!in_fifo_empty && in_cnt<IMG_PIXELS; `in_fifo_rden`=`core_img_in_valid & core_img_in_ready`; in_cnt += rden.
  - Output: `core_img_out_ready`=!out_fifo_full; `out_fifo_wren`=`core_img_out_valid & !out_fifo_full`; out_cnt += wren.
  - Stall counter: clears on any in/out handshake, otherwise increments. At STALL_LIMIT, set `error` → IDLE (abort).
  - When out_cnt reaches OUT_PIXELS → DONE. Input beyond IMG_PIXELS is never consumed; leftover words stay in the FIFO.
- DONE: `frame_done`=1 for one cycle; `frame_count`++ → IDLE.
- Abort: `streams_open`=0 in any non-IDLE state → IDLE next cycle. No `frame_done`, no count, `error` unchanged.
- All handshake outputs are 0 outside their states; the select byte is never consumed outside SELECT.

## Timing
- Reset values (`reset_n`=0): state IDLE, `core_reset`=1, `busy`=0, `frame_done`=0, `error`=0, `frame_count`=0, all strobes/valids/readies 0.
- `sel_fifo_rden`, `in_fifo_rden`, `out_fifo_wren`, `core_*_valid` and `core_img_out_ready` are combinational from state, counters and inputs. There are no registered handshake paths; a transfer completes in the cycle both sides agree.
- IDLE→SELECT latency: 1 + RESET_CYCLES cycles after a non-empty select FIFO is seen.
- The final out handshake and the DONE entry happen in consecutive cycles; `frame_done` is high the cycle after the last `out_fifo_wren`.
- Simultaneous abort and completion in STREAM: abort wins; no `frame_done`.
- Counters saturate logic is not needed: gating guarantees in_cnt ≤ IMG_PIXELS and out_cnt ≤ OUT_PIXELS.

## Test plan
Parameters for all tests: IMG_PIXELS=OUT_PIXELS=16, RESET_CYCLES=4, STALL_LIMIT=32.

- **Reset values:** assert `reset_n`=0 mid-STREAM → same cycle all outputs at reset values; `core_reset`=1, `frame_count`=0.
- **Nominal frame:** select byte 0x03, 20 words in the FIFO, core always ready/echoing → exactly 16 `in_fifo_rden`, 16 `out_fifo_wren`. `core_reset` high for 4 cycles; `frame_done` pulses once; `frame_count`=1; 4 words remain.
- **Backpressure:** `out_fifo_full` toggled every other cycle → `core_img_out_ready` mirrors it, no write while full, frame still completes with count 16.
- **Stall abort:** core stops after 10 outputs → 32 idle cycles later `error`=1, state IDLE, `core_reset`=1. `error` clears at the next CORE_RST.
- **Close abort:** `streams_open` dropped at in_cnt=7 → IDLE next cycle, no `frame_done`, `frame_count` unchanged.
- **Back-to-back:** two selects queued → two full sequences, each with a 4-cycle core reset; `frame_count`=2.
